// File: rtl/aqe_iram_loader_if.sv
// aqe_iram_loader_if
//   Bundles the host word stream, the IRAM program-write port and the load
//   status/reset-hold outputs of the boot-time program loader.
//   master : host/test side (drives request and word stream, observes results)
//   slave  : loader side (aqe_iram_loader)
// Signals:
//   ld_start, ld_len[19:0]         load request and line count
//   ld_wvalid, ld_wdata[31:0]      host word stream
//   ld_wready                      word accepted when ld_wvalid && ld_wready
//   prog_wen, prog_waddr[19:0],
//   prog_wdata[127:0]              IRAM line write port
//   ld_busy, ld_done, ld_err       load status
//   cpu_rst_hold_b                 active-low core reset hold
interface aqe_iram_loader_if;
  logic         ld_start;
  logic [19:0]  ld_len;
  logic         ld_wvalid;
  logic [31:0]  ld_wdata;
  logic         ld_wready;
  logic         prog_wen;
  logic [19:0]  prog_waddr;
  logic [127:0] prog_wdata;
  logic         ld_busy;
  logic         ld_done;
  logic         ld_err;
  logic         cpu_rst_hold_b;

  modport master (
    output ld_start, ld_len, ld_wvalid, ld_wdata,
    input  ld_wready, prog_wen, prog_waddr, prog_wdata,
    input  ld_busy, ld_done, ld_err, cpu_rst_hold_b
  );

  modport slave (
    input  ld_start, ld_len, ld_wvalid, ld_wdata,
    output ld_wready, prog_wen, prog_waddr, prog_wdata,
    output ld_busy, ld_done, ld_err, cpu_rst_hold_b
  );
endinterface

// File: rtl/aqe_iram_loader.sv
// aqe_iram_loader
//   Boot-time program loader. Packs four 32-bit host words into one 128-bit
//   IRAM line and writes lines at consecutive addresses starting at
//   BASE_LINE. Holds the core in reset (cpu_rst_hold_b=0) until the image has
//   been loaded without error.
//   Optional feature macro: AQE_LOADER_CHECKSUM_EN -- adds a CHECK state that
//   accepts one trailing word and compares it with the mod-2^32 sum of all
//   data words.
// Ports:
//   pll_core_cpuclk  core clock
//   pad_cpu_rst_b    synchronous active-low reset
//   ld_if            aqe_iram_loader_if.slave (host stream, IRAM port, status)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for first load request
// S_FILL  | collecting the four words of the current line
// S_WRITE | one-cycle IRAM write strobe for the completed line
// S_CHECK | waiting for the checksum word (checksum build only)
// S_DONE  | load finished (ok or error); accepts a new request
module aqe_iram_loader #(
  parameter int LINES     = 32768,
  parameter int BASE_LINE = 0
) (
  input logic              pll_core_cpuclk,
  input logic              pad_cpu_rst_b,
  aqe_iram_loader_if.slave ld_if
);

  localparam logic [20:0] LP_LINES  = 21'(LINES);
  localparam logic [20:0] LP_BASE21 = 21'(BASE_LINE);
  localparam logic [19:0] LP_BASE   = 20'(BASE_LINE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
`ifdef AQE_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t       r_state;
  logic [19:0]  r_len;
  logic [19:0]  r_line_cnt;
  logic [1:0]   r_word_cnt;
  logic [95:0]  r_buf;
  logic         r_wready;
  logic         r_wen;
  logic [19:0]  r_waddr;
  logic [127:0] r_wdata;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic         r_hold_b;
`ifdef AQE_LOADER_CHECKSUM_EN
  logic [31:0]  r_sum;
`endif

  logic         w_accept;
  logic [20:0]  w_range_end;
  logic         w_range_bad;
  logic         w_last_line;

  assign w_accept    = ld_if.ld_wvalid & r_wready;
  // 21-bit sum so BASE_LINE + ld_len cannot wrap past the limit
  assign w_range_end = LP_BASE21 + {1'b0, ld_if.ld_len};
  assign w_range_bad = w_range_end > LP_LINES;
  assign w_last_line = r_line_cnt == (r_len - 20'd1);

  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_line_cnt <= '0;
      r_word_cnt <= '0;
      r_buf      <= '0;
      r_wready   <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hold_b   <= 1'b0;
`ifdef AQE_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ld_if.ld_start) begin
            r_len      <= ld_if.ld_len;
            r_line_cnt <= '0;
            r_word_cnt <= '0;
`ifdef AQE_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
            if (ld_if.ld_len == 20'd0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_err    <= 1'b0;
              r_hold_b <= 1'b1;
            end else if (w_range_bad) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_hold_b <= 1'b0;
            end else begin
              r_state  <= S_FILL;
              r_busy   <= 1'b1;
              r_wready <= 1'b1;
              r_done   <= 1'b0;
              r_err    <= 1'b0;
              r_hold_b <= 1'b0;
            end
          end
        end

        S_FILL: begin
          if (w_accept) begin
`ifdef AQE_LOADER_CHECKSUM_EN
            r_sum <= r_sum + ld_if.ld_wdata;
`endif
            r_word_cnt <= r_word_cnt + 2'd1;
            if (r_word_cnt == 2'd3) begin
              r_wdata  <= {ld_if.ld_wdata, r_buf};
              r_wen    <= 1'b1;
              r_waddr  <= LP_BASE + r_line_cnt;
              r_wready <= 1'b0;
              r_state  <= S_WRITE;
            end else begin
              // shift in from the top: after three words r_buf = {w2, w1, w0}
              r_buf <= {ld_if.ld_wdata, r_buf[95:32]};
            end
          end
        end

        S_WRITE: begin
          if (w_last_line) begin
`ifdef AQE_LOADER_CHECKSUM_EN
            r_state  <= S_CHECK;
            r_wready <= 1'b1;
`else
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= 1'b0;
            r_hold_b <= 1'b1;
`endif
          end else begin
            r_line_cnt <= r_line_cnt + 20'd1;
            r_state    <= S_FILL;
            r_wready   <= 1'b1;
          end
        end

`ifdef AQE_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_state  <= S_DONE;
            r_wready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            if (r_sum == ld_if.ld_wdata) begin
              r_err    <= 1'b0;
              r_hold_b <= 1'b1;
            end else begin
              r_err    <= 1'b1;
              r_hold_b <= 1'b0;
            end
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_if.ld_wready      = r_wready;
  assign ld_if.prog_wen       = r_wen;
  assign ld_if.prog_waddr     = r_waddr;
  assign ld_if.prog_wdata     = r_wdata;
  assign ld_if.ld_busy        = r_busy;
  assign ld_if.ld_done        = r_done;
  assign ld_if.ld_err         = r_err;
  assign ld_if.cpu_rst_hold_b = r_hold_b;

endmodule

// File: tb/tb_aqe_iram_loader.sv
// tb_aqe_iram_loader
//   Directed bench for aqe_iram_loader. A word-level model predicts every IRAM
//   line write (address and packed data); a per-cycle monitor compares the
//   write port against it, and directed steps pin timing and status values.
`timescale 1ns/1ps
module tb_aqe_iram_loader;
  localparam int LINES     = 32768;
  localparam int BASE_LINE = 0;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  aqe_iram_loader_if bus();

  aqe_iram_loader #(.LINES(LINES), .BASE_LINE(BASE_LINE)) dut (
    .pll_core_cpuclk(clk),
    .pad_cpu_rst_b  (rst_b),
    .ld_if          (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [19:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [127:0] m_acc;
  int           m_words;
  int           m_line;
  int           m_len;
  logic [31:0]  m_sum;
  logic [19:0]  last_addr;
  logic [127:0] last_data;
  int           n_writes;
  bit           chk_en;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // lines are LINES deep starting at BASE_LINE; anything past the end is an error
  function automatic bit range_err(input logic [19:0] len);
    return (BASE_LINE + int'(len)) > LINES;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_words = 0;
    m_line  = 0;
    m_len   = 0;
    m_sum   = '0;
    m_acc   = '0;
  endfunction

  function automatic void model_accept(input logic [31:0] w);
    if (m_line < m_len) begin
      m_acc[32*m_words +: 32] = w;
      m_sum = m_sum + w;
      m_words++;
      if (m_words == 4) begin
        exp_q.push_back('{addr: 20'(BASE_LINE + m_line), data: m_acc});
        m_line++;
        m_words = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.prog_wen === 1'b1) begin
        n_writes++;
        check("wready_low_in_write", 128'(bus.ld_wready), 128'(0));
        check("write_was_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          last_addr = exp_q[0].addr;
          last_data = exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end
      check("prog_waddr", 128'(bus.prog_waddr), 128'(last_addr));
      check("prog_wdata", bus.prog_wdata, last_data);
      check("busy_done_excl", 128'(bus.ld_busy & bus.ld_done), 128'(0));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [19:0] len);
    bus.ld_start = 1'b1;
    bus.ld_len   = len;
    model_reset();
    m_len = (len == 20'd0 || range_err(len)) ? 0 : int'(len);
    sync();
    bus.ld_start = 1'b0;
    bus.ld_len   = 20'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    int n;
    int gap;
    bit acc;
    if (rnd) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bus.ld_wvalid = 1'b0;
        bus.ld_wdata  = $urandom;
        sync();
      end
    end
    bus.ld_wvalid = 1'b1;
    bus.ld_wdata  = w;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (bus.ld_wready === 1'b1) begin
        acc = 1'b1;
        model_accept(w);
      end
      sync();
      n++;
    end
    bus.ld_wvalid = 1'b0;
    bus.ld_wdata  = $urandom;
    check("word_accepted", 128'(acc), 128'(1));
  endtask

  // checksum builds need one trailing word equal to the data sum
  task automatic finish_load();
`ifdef AQE_LOADER_CHECKSUM_EN
    send_word(m_sum, 1'b0);
`endif
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ld_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 128'(bus.ld_done), 128'(1));
  endtask

  task automatic check_outputs_reset(input string name);
    check({name, "_wready"}, 128'(bus.ld_wready), 128'(0));
    check({name, "_wen"},    128'(bus.prog_wen), 128'(0));
    check({name, "_waddr"},  128'(bus.prog_waddr), 128'(0));
    check({name, "_wdata"},  bus.prog_wdata, 128'(0));
    check({name, "_busy"},   128'(bus.ld_busy), 128'(0));
    check({name, "_done"},   128'(bus.ld_done), 128'(0));
    check({name, "_err"},    128'(bus.ld_err), 128'(0));
    check({name, "_hold"},   128'(bus.cpu_rst_hold_b), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    bus.ld_start  = 1'b0;
    bus.ld_len    = '0;
    bus.ld_wvalid = 1'b0;
    bus.ld_wdata  = '0;
    chk_en    = 1'b0;
    n_writes  = 0;
    last_addr = '0;
    last_data = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_reset("reset");
    sync();
    rst_b  = 1'b1;
    chk_en = 1'b1;

    // single line, literal packing and status timing
    start_load(20'd1);
    @(negedge clk);
    check("t1_busy_after_start", 128'(bus.ld_busy), 128'(1));
    check("t1_wready_after_start", 128'(bus.ld_wready), 128'(1));
    sync();
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_word(32'h44444444, 1'b0);
    @(negedge clk);
    check("t1_wen", 128'(bus.prog_wen), 128'(1));
    check("t1_waddr", 128'(bus.prog_waddr), 128'(0));
    check("t1_wdata", bus.prog_wdata, 128'h44444444_33333333_22222222_11111111);
`ifndef AQE_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("t1_done_next", 128'(bus.ld_done), 128'(1));
    check("t1_hold_next", 128'(bus.cpu_rst_hold_b), 128'(1));
    check("t1_wen_single", 128'(bus.prog_wen), 128'(0));
`endif
    sync();
    finish_load();
    wait_done("t1");
    check("t1_err", 128'(bus.ld_err), 128'(0));
    check("t1_hold", 128'(bus.cpu_rst_hold_b), 128'(1));
    check("t1_busy", 128'(bus.ld_busy), 128'(0));
    sync();

    // three lines with random valid gaps
    wb = n_writes;
    start_load(20'd3);
    send_word(32'hA0A0A0A0, 1'b0);
    send_word(32'hA1A1A1A1, 1'b0);
    send_word(32'hA2A2A2A2, 1'b0);
    send_word(32'hA3A3A3A3, 1'b0);
    @(negedge clk);
    check("t2_wen", 128'(bus.prog_wen), 128'(1));
    @(negedge clk);
    check("t2_wready_again", 128'(bus.ld_wready), 128'(1));
    sync();
    for (int i = 0; i < 8; i++) send_word($urandom, 1'b1);
    finish_load();
    wait_done("t2");
    check("t2_write_count", 128'(n_writes - wb), 128'(3));
    check("t2_queue_empty", 128'(exp_q.size()), 128'(0));
    check("t2_last_addr", 128'(bus.prog_waddr), 128'(2));
    check("t2_hold", 128'(bus.cpu_rst_hold_b), 128'(1));
    sync();

    // zero length and out-of-range requests
    wb = n_writes;
    start_load(20'd0);
    @(negedge clk);
    sync();
    @(negedge clk);
    check("t3_len0_done", 128'(bus.ld_done), 128'(1));
    check("t3_len0_err", 128'(bus.ld_err), 128'(0));
    check("t3_len0_hold", 128'(bus.cpu_rst_hold_b), 128'(1));
    check("t3_len0_busy", 128'(bus.ld_busy), 128'(0));
    sync();
    start_load(20'd32769);
    @(negedge clk);
    sync();
    @(negedge clk);
    check("t3_ovf_done", 128'(bus.ld_done), 128'(1));
    check("t3_ovf_err", 128'(bus.ld_err), 128'(1));
    check("t3_ovf_hold", 128'(bus.cpu_rst_hold_b), 128'(0));
    sync();
    start_load(20'hFFFFF);
    @(negedge clk);
    sync();
    @(negedge clk);
    check("t3_max_err", 128'(bus.ld_err), 128'(1));
    check("t3_max_wready", 128'(bus.ld_wready), 128'(0));
    check("t3_no_writes", 128'(n_writes - wb), 128'(0));
    sync();

    // reset after 6 of 8 words
    wb = n_writes;
    start_load(20'd2);
    for (int i = 0; i < 6; i++) send_word(32'hC0DE0000 + 32'(i), 1'b0);
    chk_en = 1'b0;
    rst_b  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_reset("t4_midreset");
    check("t4_one_write", 128'(n_writes - wb), 128'(1));
    sync();
    rst_b = 1'b1;
    model_reset();
    last_addr = '0;
    last_data = '0;
    chk_en = 1'b1;
    wb = n_writes;
    start_load(20'd1);
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b1);
    finish_load();
    wait_done("t4_fresh");
    check("t4_fresh_writes", 128'(n_writes - wb), 128'(1));
    check("t4_fresh_addr", 128'(bus.prog_waddr), 128'(0));
    sync();

    // ld_start while busy is ignored
    wb = n_writes;
    start_load(20'd2);
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    bus.ld_start = 1'b1;
    bus.ld_len   = 20'd7;
    sync();
    bus.ld_start = 1'b0;
    @(negedge clk);
    check("t5_still_busy", 128'(bus.ld_busy), 128'(1));
    sync();
    for (int i = 0; i < 6; i++) send_word(32'h00000100 + 32'(i), 1'b1);
    finish_load();
    wait_done("t5");
    check("t5_write_count", 128'(n_writes - wb), 128'(2));
    check("t5_last_addr", 128'(bus.prog_waddr), 128'(1));
    check("t5_queue_empty", 128'(exp_q.size()), 128'(0));
    sync();

`ifdef AQE_LOADER_CHECKSUM_EN
    // checksum good / bad: 1+2+3+4 = 10
    start_load(20'd1);
    for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b0);
    send_word(32'd10, 1'b0);
    wait_done("t6_good");
    check("t6_good_err", 128'(bus.ld_err), 128'(0));
    check("t6_good_hold", 128'(bus.cpu_rst_hold_b), 128'(1));
    sync();
    start_load(20'd1);
    for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b0);
    send_word(32'd11, 1'b0);
    wait_done("t6_bad");
    check("t6_bad_err", 128'(bus.ld_err), 128'(1));
    check("t6_bad_hold", 128'(bus.cpu_rst_hold_b), 128'(0));
    sync();
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aqe_iram_loader.md
# aqe_iram_loader

Boot-time program loader sitting directly upstream of the instruction RAM's program-write port. It accepts a 32-bit word stream from the host/debug side and packs four words into one 128-bit line. Each line is written through the `prog_wen`/`prog_waddr`/`prog_wdata` port at consecutive line addresses. It holds the core in reset until the image is fully and correctly loaded.

## Interface
Parameters:
- `LINES`, 32768, number of 128-bit lines in the IRAM (15-bit line address space).
- `BASE_LINE`, 0, first line address written.

Ports (one clock, `pll_core_cpuclk`; reset `pad_cpu_rst_b` is synchronous and active-low):
- `pll_core_cpuclk` in 1: core clock.
- `pad_cpu_rst_b` in 1: synchronous active-low reset.
- `ld_start` in 1: single-cycle load request.
- `ld_len` in 20: number of lines to load; captured on an accepted `ld_start`.
- `ld_wvalid` in 1: host word valid.
- `ld_wdata` in 32: host word.
- `ld_wready` out 1: word accepted when `ld_wvalid && ld_wready`.
- `prog_wen` out 1: IRAM program write strobe.
- `prog_waddr` out 20: IRAM line address.
- `prog_wdata` out 128: IRAM line data.
- `ld_busy` out 1: load in progress.
- `ld_done` out 1: load finished; level signal.
- `ld_err` out 1: load aborted or failed; level signal.
- `cpu_rst_hold_b` out 1: active-low core reset hold, ANDed into the core reset.

## Operation
States:
- IDLE: waiting for a request.
  - `ld_start` with `ld_len==0` → DONE, no write, `ld_err=0`.
  - `ld_start` with `BASE_LINE+ld_len > LINES` → DONE with `ld_err=1`, no write.
  - Any other `ld_start` → FILL; the line counter and word counter are cleared.
- FILL: `ld_wready=1`.
  - Word k (k=0..3) of a line lands in `prog_wdata[32k+31:32k]`.
  - Acceptance of the 4th word → WRITE.
- WRITE: `prog_wen=1` for exactly one cycle, `prog_waddr=BASE_LINE+line_cnt`, `ld_wready=0`.
  - Then, if `line_cnt==len-1` → CHECK when `AQE_LOADER_CHECKSUM_EN` is defined, else DONE.
  - Otherwise `line_cnt` increments → FILL.
- DONE: `ld_done=1`, `ld_busy=0`, `ld_wready=0`.
  - `cpu_rst_hold_b=1` only if `ld_err==0`.
  - A new `ld_start` re-runs the IDLE checks: `ld_done`, `ld_err` and `cpu_rst_hold_b` clear, then → FILL or DONE.
- Other rules:
  - `ld_busy=1` in FILL, WRITE and CHECK.
  - `ld_start` is ignored while busy.
  - `ld_wvalid` is ignored outside FILL/CHECK; `ld_wdata` is ignored when not accepted.
  - `prog_wdata` holds the last written line between writes; `prog_waddr` holds its value when `prog_wen=0`.
- Arithmetic:
  - `line_cnt` is 20 bits. The range check is done at 21 bits so it cannot wrap.
  - `prog_waddr` = 20-bit sum of `BASE_LINE` and `line_cnt`.

## Timing
- All outputs are registered. Reset state:
  - State IDLE.
  - `ld_wready=0`, `prog_wen=0`, `prog_waddr=0`, `prog_wdata=0`.
  - `ld_busy=0`, `ld_done=0`, `ld_err=0`, `cpu_rst_hold_b=0`.
- `ld_start` in cycle N → `ld_busy=1` and `ld_wready=1` in N+1.
- 4th word accepted in cycle N → `prog_wen=1` in N+1, `ld_wready=1` again in N+2.
- Minimum 5 cycles per line.
- Last `prog_wen` in cycle N → `ld_done=1` and `cpu_rst_hold_b=1` in N+1 (no checksum).
- Reset asserted mid-load: state returns to IDLE on the next clock edge and all outputs take their reset values.
  - A partially filled line is discarded and never written.
  - `cpu_rst_hold_b` returns to 0.

## Configuration
- `AQE_LOADER_CHECKSUM_EN` defined:
  - A 32-bit running sum (mod 2^32) of every accepted data word is kept.
  - After the last WRITE the block enters CHECK, where `ld_wready=1` and exactly one extra word is accepted.
  - Sum equal to that word → DONE with `ld_err=0`.
  - Mismatch → DONE with `ld_err=1`; `cpu_rst_hold_b` stays 0.
  - The sum clears on each accepted `ld_start`.
- Not defined: no CHECK state and no sum register; DONE follows the last WRITE directly and `ld_err` arises only from the range check.

## Test plan
- Reset, `ld_len=1`, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → one `prog_wen` pulse with `prog_waddr=0`, `prog_wdata=0x44444444_33333333_22222222_11111111`; `ld_done=1` and `cpu_rst_hold_b=1` one cycle later.
- `ld_len=3`, `ld_wvalid` toggled randomly → exactly three `prog_wen` pulses at addresses 0, 1, 2; no write while a line is partial; `ld_wready=0` during each WRITE cycle.
- `ld_len=0` → `ld_done=1` two cycles after start, no `prog_wen`; `ld_len=32769` → `ld_done=1`, `ld_err=1`, `cpu_rst_hold_b=0`, no `prog_wen`.
- Reset asserted after 6 of 8 words with `ld_len=2` → one write only (address 0); the next cycle has all outputs at reset values; a fresh load afterwards starts at address 0.
- With `AQE_LOADER_CHECKSUM_EN`, `ld_len=1`, words 1, 2, 3, 4, then checksum 10 → `ld_err=0`, `cpu_rst_hold_b=1`; same data with checksum 11 → `ld_err=1`, `cpu_rst_hold_b=0`.
- `ld_start` pulsed during FILL → ignored; the line count and addresses are unchanged.
